// File: rtl/mux8_arbiter.sv
// Arbiter and sequencer for the shared 8:1 x 16-bit mux: picks a requester, steers
// the registered mux select, captures the word and offers it downstream on valid/ready.
module mux8_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  req,
  input  logic [15:0] mux_r,
  input  logic        out_ready,
  output logic [2:0]  sel,
  output logic [7:0]  grant,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [2:0]  out_src,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a word transfers on every rising edge where out_valid && out_ready;
  // out_valid, out_data and out_src hold stable until that edge and never depend on out_ready.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] last;
  logic [2:0] rr_w;
  logic [2:0] fp_w;
  logic [2:0] idx;
  logic [2:0] win;

  // Descending scan so the last hit is the first position in search order.
  always_comb begin
    rr_w = '0;
    fp_w = '0;
    idx  = '0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) fp_w = 3'(i);
      idx = last + 3'(i) + 3'd1;
      if (req[idx]) rr_w = idx;
    end
    win = RR_EN ? rr_w : fp_w;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      last      <= 3'd7;
    end else begin
      case (state)
        IDLE: begin
          if (req != 8'h00) begin
            sel   <= win;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          // Arbitration is committed here; a dropped req does not cancel the transfer.
          out_data  <= mux_r;
          out_src   <= sel;
          last      <= sel;
          out_valid <= 1'b1;
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded from registers only, so no input-to-output combinational path.
  assign grant     = (state == CAPTURE) ? (8'h01 << sel) : 8'h00;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mux8_arbiter.sv
// Directed bench for mux8_arbiter: a round-robin instance and a fixed-priority
// instance share requests and ready; each has its own behavioural 8:1 mux.
module tb_mux8_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  req;
  logic        out_ready;
  logic [15:0] mux_in [8];

  logic [15:0] mux_r, mux_r_fp;
  logic [2:0]  sel, sel_fp, out_src, out_src_fp;
  logic [7:0]  grant, grant_fp;
  logic        out_valid, out_valid_fp, busy, busy_fp;
  logic [15:0] out_data, out_data_fp;
  logic [1:0]  dbg_state, dbg_state_fp;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign mux_r    = mux_in[sel];
  assign mux_r_fp = mux_in[sel_fp];

  mux8_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .req(req), .mux_r(mux_r), .out_ready(out_ready),
    .sel(sel), .grant(grant), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .busy(busy), .dbg_state(dbg_state)
  );

  mux8_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .reset(reset), .req(req), .mux_r(mux_r_fp), .out_ready(out_ready),
    .sel(sel_fp), .grant(grant_fp), .out_valid(out_valid_fp), .out_data(out_data_fp),
    .out_src(out_src_fp), .busy(busy_fp), .dbg_state(dbg_state_fp)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req = 8'h00;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) mux_in[i] = 16'h1000 + 16'(i);
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tests_run++;
      if (sel !== 3'd0 || grant !== 8'h00 || out_valid !== 1'b0 || out_data !== 16'h0000 ||
          out_src !== 3'd0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle c%0d: sel=%0d grant=%h valid=%b data=%h src=%0d busy=%b, required all zero",
                 c, sel, grant, out_valid, out_data, out_src, busy);
      end
      step();
    end
  endtask

  task automatic test_single();
    mux_in[3] = 16'hBEEF;
    out_ready = 1'b1;
    req = 8'h08;
    step();
    req = 8'h00;
    tests_run++;
    if (grant !== 8'h08 || sel !== 3'd3 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_grant: grant=%h sel=%0d busy=%b, required 08 3 1", grant, sel, busy);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_src !== 3'd3 || grant !== 8'h00) begin
      tests_failed++;
      $display("FAIL single_output: valid=%b data=%h src=%0d grant=%h, required 1 beef 3 00",
               out_valid, out_data, out_src, grant);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_idle: valid=%b busy=%b, required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp;
    for (int i = 0; i < 8; i++) mux_in[i] = 16'hA000 + 16'(i * 16'h0011);
    out_ready = 1'b1;
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      exp = 3'(k % 8);
      step();
      tests_run++;
      if (grant !== (8'h01 << exp) || grant_fp !== 8'h01) begin
        tests_failed++;
        $display("FAIL rr_grant k%0d: grant=%h fp_grant=%h, required %h 01", k, grant, grant_fp, 8'h01 << exp);
      end
      step();
      tests_run++;
      if (out_valid !== 1'b1 || out_src !== exp || out_data !== 16'hA000 + 16'(exp * 16'h0011) ||
          out_valid_fp !== 1'b1 || out_src_fp !== 3'd0) begin
        tests_failed++;
        $display("FAIL rr_word k%0d: valid=%b src=%0d data=%h fp_valid=%b fp_src=%0d, required 1 %0d %h 1 0",
                 k, out_valid, out_src, out_data, out_valid_fp, out_src_fp, exp,
                 16'hA000 + 16'(exp * 16'h0011));
      end
      step();
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || grant !== 8'h00) begin
        tests_failed++;
        $display("FAIL rr_idle k%0d: valid=%b busy=%b grant=%h, required 0 0 00", k, out_valid, busy, grant);
      end
    end
    req = 8'h00;
  endtask

  task automatic test_backpressure();
    do_reset();
    mux_in[2] = 16'h5A5A;
    out_ready = 1'b0;
    req = 8'h04;
    step();
    req = 8'h00;
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 16'h5A5A || out_src !== 3'd2) begin
      tests_failed++;
      $display("FAIL bp_first: valid=%b data=%h src=%0d, required 1 5a5a 2", out_valid, out_data, out_src);
    end
    for (int c = 0; c < 5; c++) begin
      mux_in[2] = 16'($urandom_range(0, 16'hFFFF)) ^ 16'h8000;
      req = 8'hFF;
      step();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 16'h5A5A || out_src !== 3'd2 || sel !== 3'd2 ||
          grant !== 8'h00 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_hold c%0d: valid=%b data=%h src=%0d sel=%0d grant=%h busy=%b, required 1 5a5a 2 2 00 1",
                 c, out_valid, out_data, out_src, sel, grant, busy);
      end
    end
    req = 8'h00;
    out_ready = 1'b1;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: valid=%b busy=%b, required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_committed();
    do_reset();
    mux_in[5] = 16'h1234;
    out_ready = 1'b1;
    req = 8'h20;
    step();
    req = 8'h00;
    tests_run++;
    if (grant !== 8'h20) begin
      tests_failed++;
      $display("FAIL commit_grant: grant=%h, required 20", grant);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_src !== 3'd5 || out_data !== 16'h1234) begin
      tests_failed++;
      $display("FAIL commit_word: valid=%b src=%0d data=%h, required 1 5 1234", out_valid, out_src, out_data);
    end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    mux_in[1] = 16'hC0DE;
    out_ready = 1'b0;
    req = 8'h02;
    step();
    req = 8'h00;
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_src !== 3'd1) begin
      tests_failed++;
      $display("FAIL midrst_pre: valid=%b src=%0d, required 1 1", out_valid, out_src);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || sel !== 3'd0 || busy !== 1'b0 || grant !== 8'h00) begin
      tests_failed++;
      $display("FAIL midrst_clear: valid=%b data=%h sel=%0d busy=%b grant=%h, required 0 0000 0 0 00",
               out_valid, out_data, sel, busy, grant);
    end
    req = 8'h81;
    step();
    req = 8'h00;
    tests_run++;
    if (grant !== 8'h01 || sel !== 3'd0) begin
      tests_failed++;
      $display("FAIL midrst_winner: grant=%h sel=%0d, required 01 0", grant, sel);
    end
    out_ready = 1'b1;
    step();
    step();
  endtask

  initial begin
    reset = 1'b1;
    req = 8'h00;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) mux_in[i] = 16'h0000;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_committed();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
